mdu_control: RTL and testbench

//   Parametrised multiply/divide unit with its own funct decoder for the MIPS pipeline EX stage.

---
 rtl/mdu_control.sv | 202 ++++++++++++++++++++
 tb/tb_mdu_control.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_control.sv
// Iterative multiply/divide unit for the EX stage: decodes the HI/LO funct
// group, runs one-bit-per-cycle shift-add multiply and restoring divide,
// and stalls the pipeline until the HI/LO result is architecturally visible.
module mdu_control #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] mf_data,
  output logic             mf_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  // Multiplicand for multiply, divisor for divide (always a magnitude).
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               is_div_q, is_div_d;
  logic               div0_q, div0_d;

  logic               accepted;
  logic               op_mul, op_div, op_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Decode and operand magnitudes; the most negative value maps to 2**(WIDTH-1) unsigned.
  always_comb begin
    busy      = (state_q != S_IDLE);
    accepted  = start && (ALUOp == 2'b10) && !busy;
    op_mul    = accepted && ((funct == F_MULT) || (funct == F_MULTU));
    op_div    = accepted && ((funct == F_DIV)  || (funct == F_DIVU));
    op_signed = (funct == F_MULT) || (funct == F_DIV);
    a_neg     = op_signed && src_a[WIDTH-1];
    b_neg     = op_signed && src_b[WIDTH-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
  end

  // One iteration of the shift-add multiply and restoring divide datapaths,
  // plus the sign-corrected results presented in FIX.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, mcand_q};
    prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix   = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state, operand capture and HI/LO update.
  always_comb begin
    // NOTE: every _d is defaulted to its _q first so no path leaves a signal unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    is_div_d = is_div_q;
    div0_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_mul) begin
          state_d  = S_MUL;
          cnt_d    = CNT_LAST;
          mcand_d  = a_mag;
          acc_d    = {{WIDTH{1'b0}}, b_mag};
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          is_div_d = 1'b0;
        end else if (op_div) begin
          if (src_b == '0) begin
            // Divide by zero skips the datapath; result is visible in DONE.
            state_d = S_DONE;
            lo_d    = '1;
            hi_d    = src_a;
            div0_d  = 1'b1;
          end else begin
            state_d  = S_DIV;
            cnt_d    = CNT_LAST;
            mcand_d  = b_mag;
            acc_d    = {{WIDTH{1'b0}}, a_mag};
            sign_a_d = a_neg;
            sign_b_d = b_neg;
            is_div_d = 1'b1;
          end
        end else if (accepted && (funct == F_MTHI)) begin
          hi_d = src_a;
        end else if (accepted && (funct == F_MTLO)) begin
          lo_d = src_a;
        end
      end
      S_MUL: begin
        if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_DIV: begin
        if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                   acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // MFHI/MFLO read port: combinational, only valid when the read is accepted.
  always_comb begin
    mf_valid = accepted && ((funct == F_MFHI) || (funct == F_MFLO));
    mf_data  = '0;
    if (mf_valid) mf_data = (funct == F_MFHI) ? hi_q : lo_q;
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign div0 = div0_q;

  // State registers with synchronous reset that also aborts any operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
    end
  end

endmodule

// File: tb/tb_mdu_control.sv
// Directed bench for mdu_control: hand-computed HI/LO results, busy length,
// divide-by-zero pulse, stalled MFLO, MT/MF moves and mid-operation reset.
module tb_mdu_control;

  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   ALUOp;
  logic [5:0]   funct;
  logic [W-1:0] src_a, src_b;
  logic         busy;
  logic [W-1:0] mf_data;
  logic         mf_valid;
  logic [W-1:0] hi, lo;
  logic         div0;

  int checks = 0;
  int errors = 0;

  mdu_control #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .funct(funct),
    .src_a(src_a), .src_b(src_b), .busy(busy), .mf_data(mf_data),
    .mf_valid(mf_valid), .hi(hi), .lo(lo), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one instruction for a single edge, starting from a negedge.
  task automatic issue(input logic [1:0] op, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; ALUOp = op; funct = f; src_a = a; src_b = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count busy negedges after an accept; also counts div0 pulses seen.
  task automatic wait_idle(output int n_busy, output int n_div0);
    n_busy = 0;
    n_div0 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (div0) n_div0++;
      if (!busy) break;
      n_busy++;
    end
  endtask

  int nb, nd, nwait;

  initial begin
    reset = 1'b1; start = 1'b0; ALUOp = 2'b00; funct = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_mfv", mf_valid, 0);
    check("rst_mfd", mf_data, 0);
    check("rst_div0", div0, 0);

    // MULT 7 * -3 = -21
    issue(2'b10, F_MULT, 32'd7, 32'hFFFF_FFFD);
    wait_idle(nb, nd);
    check("mult_busy_len", nb, 34);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    // DIVU 100 / 7
    issue(2'b10, F_DIVU, 32'd100, 32'd7);
    wait_idle(nb, nd);
    check("divu_busy_len", nb, 34);
    check("divu_lo", lo, 14);
    check("divu_hi", hi, 2);

    // DIV -7 / 2 = -3 rem -1
    issue(2'b10, F_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(nb, nd);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // Most negative / -1 wraps
    issue(2'b10, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(nb, nd);
    check("divwrap_lo", lo, 32'h8000_0000);
    check("divwrap_hi", hi, 0);

    // Divide by zero
    issue(2'b10, F_DIV, 32'h55, 32'd0);
    wait_idle(nb, nd);
    check("div0_busy_len", nb, 1);
    check("div0_pulses", nd, 1);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h55);
    check("div0_clear", div0, 0);

    // Ignored: non-MDU funct and wrong ALUOp
    issue(2'b10, 6'd32, 32'd1, 32'd2);
    @(negedge clk);
    check("ign_funct_busy", busy, 0);
    check("ign_funct_hi", hi, 32'h55);
    issue(2'b00, F_MULT, 32'd3, 32'd3);
    @(negedge clk);
    check("ign_aluop_busy", busy, 0);
    check("ign_aluop_lo", lo, 32'hFFFF_FFFF);

    // MFLO held while MULTU 0xFFFFFFFF^2 runs
    issue(2'b10, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start = 1'b1; ALUOp = 2'b10; funct = F_MFLO;
    nwait = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mf_valid) break;
      nwait++;
    end
    check("mflo_stall_len", nwait, 34);
    check("mflo_valid", mf_valid, 1);
    check("mflo_busy", busy, 0);
    check("mflo_data", mf_data, 32'h0000_0001);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    @(posedge clk);
    #1 start = 1'b0;

    // MFHI combinational read
    @(negedge clk);
    start = 1'b1; ALUOp = 2'b10; funct = F_MFHI;
    #1;
    check("mfhi_valid", mf_valid, 1);
    check("mfhi_data", mf_data, 32'hFFFF_FFFE);
    @(posedge clk);
    #1 start = 1'b0;

    // MTHI, then reset in the middle of a MULT
    issue(2'b10, F_MTHI, 32'h1234, 32'd0);
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_busy", busy, 0);
    issue(2'b10, F_MULT, 32'd5, 32'd6);
    repeat (5) @(negedge clk);
    check("mult_midway_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("abort_stays_idle", busy, 0);

    // MTLO then MFLO
    issue(2'b10, F_MTLO, 32'h9, 32'd0);
    @(negedge clk);
    start = 1'b1; ALUOp = 2'b10; funct = F_MFLO;
    #1;
    check("mtlo_mflo_valid", mf_valid, 1);
    check("mtlo_mflo_data", mf_data, 32'h9);
    @(posedge clk);
    #1 start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so a stuck design still reaches a verdict.
  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
